// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared single-cycle ALU.
// One operation in flight at a time: IDLE accepts, EXEC drives the ALU, RESP holds the answer.
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_ctrl,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_ctrl,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,

    output logic [3:0]   alu_ctrl,
    output logic [N-1:0] alu_i0,
    output logic [N-1:0] alu_i1,
    input  logic [N:0]   alu_result,
    input  logic         alu_carry,
    input  logic         alu_overflow,
    input  logic         alu_zero,
    input  logic         alu_negative,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N:0]   rsp_result,
    output logic [3:0]   rsp_flags,
    output logic         rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic [3:0]     alu_ctrl_q, alu_ctrl_d;
    logic [N-1:0]   alu_i0_q, alu_i0_d;
    logic [N-1:0]   alu_i1_q, alu_i1_d;
    logic           rsp_id_q, rsp_id_d;
    logic [N:0]     rsp_result_q, rsp_result_d;
    logic [3:0]     rsp_flags_q, rsp_flags_d;
    logic           rsp_err_q, rsp_err_d;

    logic           grant_vld;
    logic           grant_id;
    logic [3:0]     sel_ctrl;
    logic [N-1:0]   sel_a;
    logic [N-1:0]   sel_b;
    logic           sel_legal;
    logic           accept;

    // Contention goes to whichever requester did not win last time.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        sel_ctrl  = grant_id ? req1_ctrl : req0_ctrl;
        sel_a     = grant_id ? req1_a    : req0_a;
        sel_b     = grant_id ? req1_b    : req0_b;
        sel_legal = (sel_ctrl <= 4'd12);
        accept    = (state_q == IDLE) && grant_vld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = sel_legal ? EXEC : RESP;
                end
            end
            EXEC:    state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state_q == IDLE) && grant_vld && !grant_id;
        req1_ready = (state_q == IDLE) && grant_vld &&  grant_id;
        rsp_valid  = (state_q == RESP);
    end

    // Illegal opcodes never reach the shared ALU inputs, so those stay untouched.
    always_comb begin
        last_grant_d = last_grant_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_i0_d     = alu_i0_q;
        alu_i1_d     = alu_i1_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        if (accept) begin
            last_grant_d = grant_id;
            rsp_id_d     = grant_id;
            if (sel_legal) begin
                alu_ctrl_d = sel_ctrl;
                alu_i0_d   = sel_a;
                alu_i1_d   = sel_b;
            end else begin
                rsp_result_d = '0;
                rsp_flags_d  = 4'b0000;
                rsp_err_d    = 1'b1;
            end
        end else if (state_q == EXEC) begin
            rsp_result_d = alu_result;
            rsp_flags_d  = {alu_overflow, alu_carry, alu_zero, alu_negative};
            rsp_err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            alu_ctrl_q   <= 4'd0;
            alu_i0_q     <= '0;
            alu_i1_q     <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= 4'b0000;
            rsp_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_i0_q     <= alu_i0_d;
            alu_i1_q     <= alu_i1_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_ctrl   = alu_ctrl_q;
    assign alu_i0     = alu_i0_q;
    assign alu_i1     = alu_i1_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU drives the shared ALU inputs, a transaction
// model predicts every output each cycle, and directed scenarios pin literal values.
module tb_alu_arbiter;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]   req0_ctrl, req1_ctrl;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] alu_i0, alu_i1;
    logic [N:0]   alu_result;
    logic         alu_carry, alu_overflow, alu_zero, alu_negative;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [N:0]   rsp_result;
    logic [3:0]   rsp_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctrl(alu_ctrl), .alu_i0(alu_i0), .alu_i1(alu_i1),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .alu_negative(alu_negative),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    // Returns {overflow, carry, zero, negative, result[N:0]}.
    function automatic logic [N+4:0] alu_fn(input logic [3:0] c, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [N:0] r;
        logic       ov;
        ov = 1'b0;
        case (c)
            4'd0: begin
                r  = {1'b0, a} + {1'b0, b};
                ov = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            4'd1: begin
                r  = {1'b0, a} - {1'b0, b};
                ov = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            4'd2:    r = {1'b0, a & b};
            4'd3:    r = {1'b0, a | b};
            4'd4:    r = {1'b0, a ^ b};
            4'd5:    r = {1'b0, ~a};
            4'd6:    r = {a, 1'b0};
            4'd7:    r = {2'b00, a[N-1:1]};
            4'd8:    r = {1'b0, a};
            4'd9:    r = {1'b0, b};
            4'd10:   r = {1'b0, a} + (N+1)'(1);
            4'd11:   r = {1'b0, a} - (N+1)'(1);
            4'd12:   r = {{N{1'b0}}, ($signed(a) < $signed(b))};
            default: r = '0;
        endcase
        return {ov, r[N], (r[N-1:0] == '0), r[N-1], r};
    endfunction

    logic [N+4:0] alu_out;
    assign alu_out      = alu_fn(alu_ctrl, alu_i0, alu_i1);
    assign alu_result   = alu_out[N:0];
    assign alu_overflow = alu_out[N+4];
    assign alu_carry    = alu_out[N+3];
    assign alu_zero     = alu_out[N+2];
    assign alu_negative = alu_out[N+1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: free/busy, latency countdown to response, and the answer.
    logic         m_free = 1'b1;
    int           m_wait = 0;
    logic         m_last = 1'b1;
    logic [3:0]   m_ctrl = 4'd0;
    logic [N-1:0] m_i0 = '0, m_i1 = '0;
    logic         m_id = 1'b0, m_err = 1'b0;
    logic [N:0]   m_res = '0;
    logic [3:0]   m_fl = 4'd0;
    logic         g_vld, g_id, e_rv;
    logic [3:0]   g_c;
    logic [N-1:0] g_a, g_b;
    logic [N+4:0] g_o;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_free = 1'b1; m_wait = 0; m_last = 1'b1;
            m_ctrl = 4'd0; m_i0 = '0; m_i1 = '0;
        end else begin
            g_vld = req0_valid | req1_valid;
            g_id  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
            e_rv  = !m_free && (m_wait == 0);
            chk("req0_ready", 64'(req0_ready), 64'(m_free && g_vld && !g_id));
            chk("req1_ready", 64'(req1_ready), 64'(m_free && g_vld && g_id));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
            chk("alu_ctrl", 64'(alu_ctrl), 64'(m_ctrl));
            chk("alu_i0", 64'(alu_i0), 64'(m_i0));
            chk("alu_i1", 64'(alu_i1), 64'(m_i1));
            if (e_rv) begin
                chk("rsp_id", 64'(rsp_id), 64'(m_id));
                chk("rsp_result", 64'(rsp_result), 64'(m_res));
                chk("rsp_flags", 64'(rsp_flags), 64'(m_fl));
                chk("rsp_err", 64'(rsp_err), 64'(m_err));
            end
            if (m_free && g_vld) begin
                g_c = g_id ? req1_ctrl : req0_ctrl;
                g_a = g_id ? req1_a : req0_a;
                g_b = g_id ? req1_b : req0_b;
                m_free = 1'b0; m_last = g_id; m_id = g_id;
                if (g_c <= 4'd12) begin
                    g_o = alu_fn(g_c, g_a, g_b);
                    m_ctrl = g_c; m_i0 = g_a; m_i1 = g_b;
                    m_res = g_o[N:0]; m_fl = g_o[N+4:N+1]; m_err = 1'b0; m_wait = 1;
                end else begin
                    m_res = '0; m_fl = 4'd0; m_err = 1'b1; m_wait = 0;
                end
            end else if (!m_free && m_wait > 0) begin
                m_wait = m_wait - 1;
            end else if (e_rv && rsp_ready) begin
                m_free = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic [3:0] c, input logic [N-1:0] a,
                         input logic [N-1:0] b);
        logic got;
        got = 1'b0;
        if (k == 0) begin
            req0_ctrl = c; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_ctrl = c; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            if (!got) begin
                @(negedge clk);
                if ((k == 0) ? req0_ready : req1_ready) got = 1'b1;
            end
        end
        if (!got) chk("issue_timeout", 64'(got), 1);
        step();
        if (k == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [N:0] res, output logic [3:0] fl, output logic id);
        logic got;
        got = 1'b0; res = '0; fl = 4'd0; id = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!got) begin
                @(negedge clk);
                if (rsp_valid && rsp_ready) begin
                    got = 1'b1; res = rsp_result; fl = rsp_flags; id = rsp_id;
                end
            end
        end
        if (!got) chk("rsp_timeout", 64'(got), 1);
        step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
        chk({tag, "_rsp_id"}, 64'(rsp_id), 0);
        chk({tag, "_rsp_result"}, 64'(rsp_result), 0);
        chk({tag, "_rsp_flags"}, 64'(rsp_flags), 0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 0);
        chk({tag, "_alu_ctrl"}, 64'(alu_ctrl), 0);
        chk({tag, "_alu_i0"}, 64'(alu_i0), 0);
        chk({tag, "_alu_i1"}, 64'(alu_i1), 0);
    endtask

    int           g_ids[$];
    int           g_cycs[$];
    logic [N:0]   r_res;
    logic [3:0]   r_fl;
    logic         r_id;

    initial begin
        rst_n = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_ctrl = 4'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_ctrl = 4'd0; req1_a = '0; req1_b = '0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("init");
        chk("init_req0_ready", 64'(req0_ready), 0);
        chk("init_req1_ready", 64'(req1_ready), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Contention straight after reset: grants 0,1,0,1 spaced three cycles apart.
        req0_ctrl = 4'd0; req0_a = 8'd100; req0_b = 8'd27;
        req1_ctrl = 4'd1; req1_a = 8'd3;   req1_b = 8'd5;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req0_ready) begin g_ids.push_back(0); g_cycs.push_back(i); end
            if (req1_ready) begin g_ids.push_back(1); g_cycs.push_back(i); end
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("contention_grants", 64'(g_ids.size()), 4);
        for (int k = 0; k < g_ids.size() && k < 4; k++) begin
            chk("contention_id", 64'(g_ids[k]), 64'(k % 2));
            chk("contention_cycle", 64'(g_cycs[k]), 64'(3 * k));
        end
        repeat (4) step();

        // Single add 5+7 from requester 0.
        req0_ctrl = 4'd0; req0_a = 8'd5; req0_b = 8'd7; req0_valid = 1'b1;
        @(negedge clk);
        chk("single_ready0", 64'(req0_ready), 1);
        chk("single_ready1", 64'(req1_ready), 0);
        step();
        req0_valid = 1'b0;
        chk("single_alu_ctrl", 64'(alu_ctrl), 0);
        chk("single_alu_i0", 64'(alu_i0), 5);
        chk("single_alu_i1", 64'(alu_i1), 7);
        chk("single_exec_valid", 64'(rsp_valid), 0);
        step();
        chk("single_rsp_valid", 64'(rsp_valid), 1);
        chk("single_rsp_id", 64'(rsp_id), 0);
        chk("single_rsp_result", 64'(rsp_result), 12);
        chk("single_rsp_flags", 64'(rsp_flags), 0);
        step();
        chk("single_done", 64'(rsp_valid), 0);

        // Backpressure with requester 1 waiting: XOR F0^3C = CC, negative.
        rsp_ready = 1'b0;
        issue(0, 4'd4, 8'hF0, 8'h3C);
        req1_ctrl = 4'd2; req1_a = 8'hF0; req1_b = 8'h3C; req1_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 1);
            chk("bp_result", 64'(rsp_result), 9'h0CC);
            chk("bp_flags", 64'(rsp_flags), 4'b0001);
            chk("bp_no_ready1", 64'(req1_ready), 0);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(rsp_valid), 1);
        step();
        @(negedge clk);
        chk("bp_after_valid", 64'(rsp_valid), 0);
        chk("bp_after_ready1", 64'(req1_ready), 1);
        step();
        req1_valid = 1'b0;
        wait_rsp(r_res, r_fl, r_id);
        chk("and_result", 64'(r_res), 9'h030);
        chk("and_id", 64'(r_id), 1);

        // Illegal opcode 14: one-cycle latency, ALU inputs untouched.
        req1_ctrl = 4'd14; req1_a = 8'h11; req1_b = 8'h22; req1_valid = 1'b1;
        @(negedge clk);
        chk("ill_ready1", 64'(req1_ready), 1);
        step();
        req1_valid = 1'b0;
        chk("ill_rsp_valid", 64'(rsp_valid), 1);
        chk("ill_rsp_err", 64'(rsp_err), 1);
        chk("ill_rsp_result", 64'(rsp_result), 0);
        chk("ill_rsp_flags", 64'(rsp_flags), 0);
        chk("ill_rsp_id", 64'(rsp_id), 1);
        chk("ill_alu_ctrl", 64'(alu_ctrl), 2);
        chk("ill_alu_i0", 64'(alu_i0), 8'hF0);
        step();

        // Zero flag, signed overflow, and carry into bit N.
        issue(0, 4'd1, 8'd9, 8'd9);
        wait_rsp(r_res, r_fl, r_id);
        chk("zero_result", 64'(r_res), 0);
        chk("zero_flags", 64'(r_fl), 4'b0010);
        issue(1, 4'd0, 8'd127, 8'd1);
        wait_rsp(r_res, r_fl, r_id);
        chk("ovf_result", 64'(r_res), 9'h080);
        chk("ovf_flags", 64'(r_fl), 4'b1001);
        issue(0, 4'd0, 8'd255, 8'd1);
        wait_rsp(r_res, r_fl, r_id);
        chk("carry_result", 64'(r_res), 9'h100);
        chk("carry_flags", 64'(r_fl), 4'b0110);

        // Reset while the operation is in EXEC.
        issue(1, 4'd4, 8'hAA, 8'h55);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_no_rsp", 64'(rsp_valid), 0);
        end
        step();
        req0_ctrl = 4'd8; req0_a = 8'd1; req0_b = 8'd2; req0_valid = 1'b1;
        req1_ctrl = 4'd9; req1_a = 8'd3; req1_b = 8'd4; req1_valid = 1'b1;
        @(negedge clk);
        chk("post_reset_grant0", 64'(req0_ready), 1);
        chk("post_reset_grant1", 64'(req1_ready), 0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(r_res, r_fl, r_id);
        chk("post_reset_id", 64'(r_id), 0);
        chk("post_reset_result", 64'(r_res), 1);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, the ALU operand width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports reqK_valid  input  1  requester K (K=0,1) has an operation pending.
REQ-005 SHALL have ports reqK_ready  output  1  arbiter accepts requester K this cycle.
REQ-006 SHALL have ports reqK_ctrl  input  4  ALU opcode; reqK_a, reqK_b  input  N  operands.
REQ-007 SHALL have ports alu_ctrl  output  4, alu_i0, alu_i1  output  N; these drive the shared ALU.
REQ-008 SHALL have ports alu_result  input  N+1, alu_carry, alu_overflow, alu_zero, alu_negative  input  1 each; these are the ALU outputs.
REQ-009 SHALL have port rsp_valid  output  1  response holds a completed result.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes the response.
REQ-011 SHALL have ports rsp_id  output  1 (requester index), rsp_result  output  N+1, rsp_flags  output  4 ({overflow,carry,zero,negative}), rsp_err  output  1 (illegal opcode).

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-013 IDLE: grant chosen combinationally from reqK_valid; if none valid, stay IDLE, both ready low.
REQ-014 Grant: single valid requester wins; both valid -> requester other than last_grant wins (round-robin).
REQ-015 reqK_ready SHALL be high only in IDLE and only for the granted K; at most one ready high per cycle.
REQ-016 On accept (valid&ready): register opcode, operands, id; set last_grant=K.
REQ-017 Accepted opcode 0..12: registered alu_ctrl/alu_i0/alu_i1 update at the accept edge; go to EXEC.
REQ-018 Accepted opcode 13..15: ALU outputs not updated; go straight to RESP with rsp_err=1, rsp_result=0, rsp_flags=0.
REQ-019 EXEC lasts exactly one cycle; at its end, capture alu_result into rsp_result, flags into rsp_flags, rsp_err=0; go to RESP.
REQ-020 Latency: accept edge T -> rsp_valid high from cycle after edge T+1 (legal op) or after edge T (illegal op).
REQ-021 RESP: rsp_valid high, rsp_id/result/flags/err stable until rsp_valid&rsp_ready; then go to IDLE.
REQ-022 rsp_valid SHALL be high only in RESP; rsp_ready ignored elsewhere.
REQ-023 No new request accepted outside IDLE; minimum 3 cycles per legal op, 2 per illegal op.
REQ-024 alu_ctrl/alu_i0/alu_i1 SHALL hold their last values outside accept edges (no glitching of shared ALU inputs).
REQ-025 last_grant SHALL change only on accept; requester deasserting valid before ready loses nothing, no state change.
REQ-026 Arithmetic: no width conversion; rsp_result is alu_result bit-for-bit including bit N.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, last_grant=1, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0, alu_ctrl=0, alu_i0=0, alu_i1=0.
REQ-028 Reset mid-EXEC or mid-RESP SHALL discard the pending operation; no response issued after release.
REQ-029 After release, first cycle with both valid SHALL grant requester 0.

Verification
REQ-030 Single op: req0 ctrl=0, a=5, b=7 -> ready0 1 cycle, alu_ctrl=0/i0=5/i1=7 next cycle, rsp_valid 2 cycles after accept, rsp_id=0, rsp_result=12, flags=0000.
REQ-031 Contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; each op 3 cycles; rsp_id sequence 0,1,0,1.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp outputs stable, no ready pulses, proceeds 1 cycle after rsp_ready=1.
REQ-033 Illegal op: req1 ctrl=14 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_result=0, alu_ctrl unchanged.
REQ-034 Zero flag: ctrl=1, a=9, b=9 -> rsp_result bit N-1..0 = 0, rsp_flags zero bit=1.
REQ-035 Reset: assert rst_n=0 during EXEC -> all outputs at reset values asynchronously; no rsp_valid after release until new accept.
